// File: rtl/aexm_pkg.sv
// aexm_pkg: shared opcode constants, interrupt vector layout and decode helpers.
package aexm_pkg;
    localparam logic [5:0]  OPC_IMM    = 6'o54;
    localparam logic [5:0]  OPC_RTD    = 6'o55;
    localparam logic [5:0]  OPC_BRU    = 6'o46;
    localparam logic [5:0]  OPC_BRUI   = 6'o56;
    localparam logic [5:0]  OPC_BCC    = 6'o47;
    localparam logic [5:0]  OPC_BCCI   = 6'o57;
    localparam logic [5:0]  OPC_MUL    = 6'o20;
    localparam logic [5:0]  OPC_MULI   = 6'o30;
    localparam logic [5:0]  OPC_BSF    = 6'o21;
    localparam logic [5:0]  OPC_BSFI   = 6'o31;
    localparam logic [31:0] INT_BASE   = 32'hB9CE0000;
    localparam logic [15:0] VEC_BASE   = 16'h0010;
    localparam logic [15:0] VEC_STRIDE = 16'h0020;
    localparam logic [31:0] NOP_WORD   = 32'h80000000;

    // An interrupt must not split an IMM prefix or land in a branch delay slot.
    function automatic logic no_inject(input logic [5:0] opc);
        return opc inside {OPC_IMM, OPC_RTD, OPC_BRU, OPC_BRUI, OPC_BCC, OPC_BCCI};
    endfunction

    function automatic logic is_multi(input logic [5:0] opc);
        return opc inside {OPC_MUL, OPC_MULI, OPC_BSF, OPC_BSFI};
    endfunction

    function automatic logic is_ldst(input logic [5:0] opc);
        return {opc[5:4], opc[2]} inside {3'o6, 3'o7};
    endfunction
endpackage

// File: rtl/aexm_ifq_fifo.sv
// aexm_ifq_fifo: DEPTH x 32 circular instruction buffer with occupancy count.
module aexm_ifq_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        rptr_d  = flush_i ? '0 : rptr_q + AW'(pop_i);
        wptr_d  = flush_i ? '0 : wptr_q + AW'(push_i);
        count_d = flush_i ? '0 : count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = count_q == (AW+1)'(DEPTH);
endmodule

// File: rtl/aexm_ifq.sv
// aexm_ifq: prefetch queue, interrupt injection, decode registers and multi-cycle stall.
module aexm_ifq
    import aexm_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int NINT      = 2,
    parameter int STALL_CYC = 2
) (
    input  logic            gclk,
    input  logic            grst,
    input  logic            d_en,
    input  logic            oena,
    input  logic            flush,
    input  logic            rMSR_IE,
    input  logic            fill_valid,
    input  logic [31:0]     fill_data,
    output logic            fill_ready,
    input  logic [NINT-1:0] sys_int_i,
    output logic [NINT-1:0] int_ack,
    output logic [31:0]     xIREG,
    output logic [5:0]      rOPC,
    output logic [4:0]      rRD,
    output logic [4:0]      rRA,
    output logic [15:0]     rIMM,
    output logic [31:0]     rSIMM,
    output logic            rVALID,
    output logic            fSTALL
);
    logic [31:0]            head;
    logic [$clog2(DEPTH):0] count;
    logic                   full, has_word, inject, push, pop;
    logic [NINT-1:0]        sync1_q, sync2_q, pend_q, pend_d;
    logic [2:0]             idx;
    logic [15:0]            vec;
    logic [3:0]             stall_q, stall_d;

    assign has_word   = count != '0;
    assign fill_ready = !full;
    assign inject     = |pend_q && rMSR_IE && !no_inject(rOPC) && d_en && !flush && !grst;
    assign push       = fill_valid && !full && !flush;
    assign pop        = d_en && has_word && !inject && !flush;

    aexm_ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (gclk),
        .rst_i   (grst),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (fill_data),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full)
    );

    always_comb begin
        idx = '0;
        for (int k = NINT - 1; k >= 0; k--) if (pend_q[k]) idx = 3'(k);
    end

    assign vec     = VEC_BASE + VEC_STRIDE * {13'd0, idx};
    assign int_ack = inject ? pend_q & (~pend_q + NINT'(1)) : '0;
    assign xIREG   = inject ? (INT_BASE | {16'h0, vec}) : has_word ? head : NOP_WORD;
    assign pend_d  = rMSR_IE ? (pend_q | sync2_q) & ~int_ack : '0;

    always_ff @(posedge gclk) begin
        if (grst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            pend_q  <= '0;
        end else begin
            pend_q <= pend_d;
            if (rMSR_IE) begin
                sync1_q <= sys_int_i;
                sync2_q <= sync1_q;
            end
        end
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            {rOPC, rRD, rRA, rIMM} <= '0;
            rSIMM  <= '0;
            rVALID <= 1'b0;
        end else if (d_en) begin
            {rOPC, rRD, rRA, rIMM} <= xIREG;
            rSIMM  <= (rOPC == OPC_IMM) ? {rIMM, xIREG[15:0]} : {{16{xIREG[15]}}, xIREG[15:0]};
            rVALID <= (inject || has_word) && !flush;
        end
    end

    // A new stall is only armed once the previous one has drained to zero.
    assign stall_d = !oena ? 4'd0
                   : stall_q != 4'd0 ? stall_q - 4'd1
                   : (is_multi(xIREG[31:26]) || is_ldst(rOPC)) ? 4'(STALL_CYC) : 4'd0;
    assign fSTALL  = stall_q != 4'd0;

    always_ff @(posedge gclk) begin
        if (grst) stall_q <= '0;
        else stall_q <= stall_d;
    end
endmodule

// File: tb/tb_aexm_ifq.sv
// tb_aexm_ifq: directed and randomized stimulus against a queue-based behavioural model.
module tb_aexm_ifq;
    logic        gclk = 1'b0;
    logic        grst = 1'b1, d_en = 1'b0, oena = 1'b0, flush = 1'b0, rMSR_IE = 1'b0, fill_valid = 1'b0;
    logic [31:0] fill_data = '0;
    logic [1:0]  sys_int_i = '0;
    logic        fill_ready, rVALID, fSTALL;
    logic [1:0]  int_ack;
    logic [31:0] xIREG, rSIMM;
    logic [5:0]  rOPC;
    logic [4:0]  rRD, rRA;
    logic [15:0] rIMM;

    aexm_ifq dut (
        .gclk(gclk), .grst(grst), .d_en(d_en), .oena(oena), .flush(flush), .rMSR_IE(rMSR_IE),
        .fill_valid(fill_valid), .fill_data(fill_data), .fill_ready(fill_ready),
        .sys_int_i(sys_int_i), .int_ack(int_ack), .xIREG(xIREG), .rOPC(rOPC), .rRD(rRD),
        .rRA(rRA), .rIMM(rIMM), .rSIMM(rSIMM), .rVALID(rVALID), .fSTALL(fSTALL)
    );

    always #5 gclk = ~gclk;

    int          n_chk = 0, n_err = 0;
    logic [31:0] q[$];
    logic [1:0]  s1 = '0, s2 = '0, pend = '0;
    logic [31:0] ir = '0, simm = '0;
    logic        valid = 1'b0;
    int          cnt = 0;
    logic [5:0]  ops[8] = '{6'o54, 6'o55, 6'o46, 6'o20, 6'o30, 6'o21, 6'o60, 6'o70};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, de, oe, fl, ie, fv, input logic [31:0] fd, input logic [1:0] irq);
        logic        inj;
        int          lo, nc;
        logic [31:0] ex;
        logic [1:0]  ack, pn;
        @(negedge gclk);
        grst = rst; d_en = de; oena = oe; flush = fl; rMSR_IE = ie;
        fill_valid = fv; fill_data = fd; sys_int_i = irq;
        #1;
        inj = !rst && de && !fl && ie && pend != 0 && !(ir[31:26] inside {6'o54, 6'o55, 6'o46, 6'o56, 6'o47, 6'o57});
        lo  = pend[0] ? 0 : 1;
        ack = inj ? 2'(1 << lo) : 2'b00;
        ex  = inj ? 32'hB9CE0000 + 32'h10 + 32'h20 * lo : q.size() != 0 ? q[0] : 32'h80000000;
        chk("xIREG", xIREG, ex);
        chk("fill_ready", 32'(fill_ready), 32'(q.size() != 4));
        chk("int_ack", 32'(int_ack), 32'(ack));
        chk("fSTALL", 32'(fSTALL), 32'(cnt != 0));
        chk("fields", {rOPC, rRD, rRA, rIMM}, ir);
        chk("rSIMM", rSIMM, simm);
        chk("rVALID", 32'(rVALID), 32'(valid));
        @(posedge gclk);
        if (rst) begin
            q.delete(); s1 = '0; s2 = '0; pend = '0; cnt = 0; ir = '0; simm = '0; valid = 1'b0;
        end else begin
            nc = !oe ? 0 : cnt != 0 ? cnt - 1
               : (ex[31:26] inside {6'o20, 6'o30, 6'o21, 6'o31} || ir[31:30] == 2'b11) ? 2 : 0;
            if (de) begin
                simm  = ir[31:26] == 6'o54 ? {ir[15:0], ex[15:0]} : {{16{ex[15]}}, ex[15:0]};
                ir    = ex;
                valid = (inj || q.size() != 0) && !fl;
            end
            if (fl) q.delete();
            else begin
                logic do_push;
                do_push = fv && q.size() != 4;
                if (de && q.size() != 0 && !inj) void'(q.pop_front());
                if (do_push) q.push_back(fd);
            end
            pn = ie ? (pend | s2) & ~ack : 2'b00;
            if (ie) begin s2 = s1; s1 = irq; end
            pend = pn;
            cnt  = nc;
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [1:0]  irq;
        repeat (3) @(posedge gclk);
        step(0, 1, 1, 0, 0, 0, 32'h0, 2'b00);
        step(0, 0, 1, 0, 0, 1, 32'h30A00005, 2'b00);
        step(0, 1, 1, 0, 0, 0, 32'h0, 2'b00);
        #1;
        chk("req039_opc", 32'(rOPC), 32'o14);
        chk("req039_simm", rSIMM, 32'h5);
        step(0, 0, 1, 0, 0, 1, 32'hB0001234, 2'b00);
        step(0, 0, 1, 0, 0, 1, 32'h3021ABCD, 2'b00);
        step(0, 1, 1, 0, 0, 0, 32'h0, 2'b00);
        step(0, 1, 1, 0, 0, 0, 32'h0, 2'b00);
        #1;
        chk("req040_simm", rSIMM, 32'h1234ABCD);
        repeat (3) step(0, 0, 1, 0, 1, 1, 32'h11111111, 2'b10);
        step(0, 1, 1, 0, 1, 0, 32'h0, 2'b10);
        #1;
        chk("req041_ir", {rOPC, rRD, rRA, rIMM}, 32'hB9CE0030);
        step(0, 1, 1, 0, 0, 0, 32'h0, 2'b00);
        repeat (5) step(0, 0, 1, 0, 0, 1, 32'h22222222, 2'b00);
        step(0, 0, 1, 1, 0, 1, 32'h33333333, 2'b00);
        step(0, 1, 1, 0, 0, 0, 32'h0, 2'b00);
        #1;
        chk("req043_valid", 32'(rVALID), 32'h0);
        irq = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) irq = 2'($urandom);
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[31:26] = ops[$urandom_range(0, 7)];
            step($urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 85,
                 $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 60, w, irq);
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/aexm_ifq.md
AEXM_IFQ -- requirements
Module: aexm_ifq

Interface
REQ-001 Parameter DEPTH, default 4, prefetch queue entries; power of 2, 2..16.
REQ-002 Parameter NINT, default 2, interrupt request lines; 1..8.
REQ-003 Parameter STALL_CYC, default 2, fSTALL cycles per multi-cycle op; 1..15.
REQ-004 gclk  in  1  single clock; all state on rising edge.
REQ-005 grst  in  1  reset, synchronous, active-high.
REQ-006 d_en  in  1  decode advance enable; loads pipeline registers.
REQ-007 oena  in  1  execute enable; low clears stall counter.
REQ-008 flush  in  1  branch-taken flush of queue.
REQ-009 rMSR_IE  in  1  interrupt enable.
REQ-010 fill_valid  in  1  icache word valid.
REQ-011 fill_data  in  32  icache instruction word.
REQ-012 fill_ready  out  1  queue accepts a word.
REQ-013 sys_int_i  in  NINT  level interrupt requests.
REQ-014 int_ack  out  NINT  one-hot, one-cycle pulse on injection.
REQ-015 xIREG  out  32  combinational next instruction into decode.
REQ-016 rOPC/rRD/rRA/rIMM  out  6/5/5/16  registered instruction fields.
REQ-017 rSIMM  out  32  registered sign-extended or IMM-merged immediate.
REQ-018 rVALID  out  1  registered instruction is real (not bubble).
REQ-019 fSTALL  out  1  multi-cycle stall request.

Function
REQ-020 Queue: DEPTH-entry circular buffer, count 0..DEPTH; fill_ready = count != DEPTH, no bypass.
REQ-021 Push on fill_valid & fill_ready; pop on d_en & count != 0 & !inject; push+pop same cycle leaves count unchanged.
REQ-022 Pointers wrap modulo DEPTH; push into empty queue visible at head next cycle.
REQ-023 flush overrides push/pop: count and pointers cleared, concurrent fill word dropped.
REQ-024 Per-line interrupt path: 2-flop synchroniser updated only while rMSR_IE; pending bit sets on synchronised high, clears on its int_ack or when rMSR_IE low.
REQ-025 inject = any pending & rMSR_IE & rOPC not in {o54 IMM, o55 RTD, o46, o56, o47, o57} & d_en & !flush.
REQ-026 Injected word: 32'hB9CE0000 | vector; vector = 16'h0010 + 16'h0020*i, i = lowest-index pending line (line0 0x0010, line1 0x0030).
REQ-027 xIREG = injected word if inject, else head entry if count != 0, else 32'h80000000.
REQ-028 On d_en: {rOPC,rRD,rRA,rIMM} <= xIREG; rVALID <= inject | count != 0 (0 when flush).
REQ-029 rSIMM on d_en: if rOPC == o54, {rIMM, xIREG[15:0]}; else sign-extend xIREG[15:0].
REQ-030 Pipeline registers hold when d_en low; queue and interrupt logic keep running.
REQ-031 Stall counter 4 bits: when oena & counter==0 & (xIREG[31:26] in {o20,o30,o21,o31} or rOPC is load ({[5:4],[2]}==3'o6) or store (==3'o7)), load STALL_CYC.
REQ-032 Counter != 0 decrements when oena; oena low forces 0; fSTALL = counter != 0 (STALL_CYC cycles high).
REQ-033 Back-to-back qualifying ops: new load only after counter returns to 0.

Reset
REQ-034 grst clears queue, pointers, synchronisers, pending, stall counter; rOPC/rRD/rRA/rIMM/rSIMM/rVALID = 0; fill_ready=1; int_ack=0; fSTALL=0.
REQ-035 grst mid-operation discards queued words and pending interrupts the same edge; no int_ack generated.

Structure
REQ-036 Shared package aexm_pkg holds opcode constants (IMM, RTD, BRU, BCC, MUL, BSF), interrupt base word, vector base/stride, NOP word.
REQ-037 One sub-module aexm_ifq_fifo (DEPTH x 32 circular buffer with count); interrupt, decode regs, stall in top.

Verification
REQ-038 Push 4 words (DEPTH=4), d_en low -> fill_ready=0 after 4th; 5th word not accepted; count stays 4.
REQ-039 Queue empty, d_en high -> xIREG=32'h80000000, rVALID=0; push 32'h30A00005 -> next cycle rOPC=6'o14, rSIMM=32'h5.
REQ-040 Queue {32'hB0001234, 32'h3021ABCD}, two d_en -> rSIMM=32'h1234ABCD.
REQ-041 rMSR_IE=1, sys_int_i=2'b10, rOPC=add -> injected xIREG=32'hB9CE0030, int_ack=2'b10, head not popped; with rOPC=o54 injection deferred one instruction.
REQ-042 xIREG opcode o20 with oena=1 -> fSTALL high exactly 2 cycles; oena dropped after first -> fSTALL low next cycle.
REQ-043 flush with fill_valid and count=3 -> count 0, word dropped, next d_en rVALID=0.
